// File: rtl/loop_pkg.sv
// Shared types and constants for the loop-playback reader.
package loop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2
    } loop_state_t;

    localparam int LOOP_CNT_W = 8;

endpackage

// File: rtl/loop_out_reg.sv
// Playback output register: a load captures a byte and raises valid; 1-cycle latency.
// While valid is high and ready is low, data and valid hold; an accepted byte without a reload clears valid.
module loop_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/loop_reader.sv
// Loops sample-memory reads over [loop_start, loop_end]; first byte 2 cycles after start, then 1/cycle.
// out_ready low stalls address and output; LOOP_READER_REVERSE_EN adds the reverse input for descending playback.
module loop_reader
    import loop_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_W-1:0]     loop_start,
    input  logic [ADDR_W-1:0]     loop_end,
`ifdef LOOP_READER_REVERSE_EN
    input  logic                  reverse,
`endif
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  loop_wrap,
    output logic                  cfg_err,
    output logic [LOOP_CNT_W-1:0] loop_cnt
);

    loop_state_t             r_state;
    loop_state_t             w_state_nxt;
    logic [ADDR_W-1:0]       r_addr;
    logic [ADDR_W-1:0]       r_ls;
    logic [ADDR_W-1:0]       r_le;
    logic                    r_rev;
    logic                    r_wrap;
    logic                    r_err;
    logic [LOOP_CNT_W-1:0]   r_cnt;

    logic                    w_go;
    logic                    w_bad;
    logic                    w_load;
    logic                    w_valid;
    logic                    w_rev_in;
    logic                    w_at_wrap;
    logic [ADDR_W-1:0]       w_addr_nxt;

`ifdef LOOP_READER_REVERSE_EN
    assign w_rev_in = reverse;
`else
    assign w_rev_in = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // stop takes priority over a load in PLAY; start is only honoured in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_bad       = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (loop_start <= loop_end) begin
                        w_go        = 1'b1;
                        w_state_nxt = PLAY;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (stop) w_state_nxt = DRAIN;
                else      w_load      = !w_valid || out_ready;
            end
            DRAIN: begin
                if (!w_valid || out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_at_wrap = r_rev ? (r_addr == r_ls) : (r_addr == r_le);
        if (w_at_wrap)  w_addr_nxt = r_rev ? r_le : r_ls;
        else if (r_rev) w_addr_nxt = r_addr - ADDR_W'(1);
        else            w_addr_nxt = r_addr + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_ls   <= '0;
            r_le   <= '0;
            r_rev  <= 1'b0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_wrap <= w_load && w_at_wrap;
            r_err  <= w_bad;
            if (w_go) begin
                r_ls   <= loop_start;
                r_le   <= loop_end;
                r_rev  <= w_rev_in;
                r_addr <= w_rev_in ? loop_end : loop_start;
                r_cnt  <= '0;
            end else if (w_load) begin
                r_addr <= w_addr_nxt;
                if (w_at_wrap) r_cnt <= r_cnt + LOOP_CNT_W'(1);
            end
        end
    end

    loop_out_reg #(.DATA_W(DATA_W)) u_out (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (rd_data),
        .i_ready (out_ready),
        .o_data  (out_data),
        .o_valid (w_valid)
    );

    assign out_valid = w_valid;
    assign rd_addr   = r_addr;
    assign busy      = (r_state != IDLE);
    assign loop_wrap = r_wrap;
    assign cfg_err   = r_err;
    assign loop_cnt  = r_cnt;

endmodule

// File: tb/tb_loop_reader.sv
// Self-checking bench for loop_reader: directed vector table, hand sequences, randomized rounds vs. a stream model.
module tb_loop_reader;

    logic       clk = 1'b0;
    logic       rst, start, stop, out_ready;
    logic [7:0] loop_start, loop_end, rd_addr, rd_data, out_data, loop_cnt;
    logic       out_valid, busy, loop_wrap, cfg_err;
`ifdef LOOP_READER_REVERSE_EN
    logic       reverse;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // memory contents are a bijection of the address so each byte identifies its source
    assign rd_data = rd_addr ^ 8'hA5;

    loop_reader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .loop_start (loop_start),
        .loop_end   (loop_end),
`ifdef LOOP_READER_REVERSE_EN
        .reverse    (reverse),
`endif
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .loop_wrap  (loop_wrap),
        .cfg_err    (cfg_err),
        .loop_cnt   (loop_cnt)
    );

    typedef struct {
        logic       st, sp;
        logic [7:0] ls, le;
        logic       rdy;
        logic       e_busy, e_vld;
        logic [7:0] e_daddr, e_addr;
        logic       e_wrap, e_err;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tv[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic st, sp, input logic [7:0] ls, le, input logic rdy,
                       input logic b, v, input logic [7:0] da, a,
                       input logic w, e, input logic [7:0] c);
        vec_t t;
        t.st = st; t.sp = sp; t.ls = ls; t.le = le; t.rdy = rdy;
        t.e_busy = b; t.e_vld = v; t.e_daddr = da; t.e_addr = a;
        t.e_wrap = w; t.e_err = e; t.e_cnt = c;
        tv.push_back(t);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rev(input logic rv);
`ifdef LOOP_READER_REVERSE_EN
        reverse = rv;
`else
        if (rv) $display("note: reverse requested in a forward-only build");
`endif
    endtask

    // Stream model: accepted bytes must walk the loop cyclically; loop_cnt equals the
    // number of wrap-address bytes delivered so far; loop_wrap marks a freshly shown wrap byte.
    task automatic run_round(input logic [7:0] ls, input logic [7:0] le, input logic rv, input int ncyc);
        logic [7:0] exp_a, wrap_a, nwrap, pd, paddr, da;
        logic       pv, pr, fresh;
        exp_a  = rv ? le : ls;
        wrap_a = rv ? ls : le;
        nwrap  = 8'd0;
        pv = 1'b0; pr = 1'b0; pd = 8'd0; paddr = 8'd0;
        start = 1'b1; stop = 1'b0; loop_start = ls; loop_end = le; set_rev(rv);
        for (int c = 0; c < ncyc + 14; c++) begin
            if (c > 0) begin
                start      = (c < ncyc) ? ($urandom_range(0, 3) == 0) : 1'b0;
                loop_start = 8'($urandom);
                loop_end   = 8'($urandom);
                set_rev(1'($urandom));
                set_rev(rv ^ 1'($urandom));
            end
            stop      = (c == ncyc);
            out_ready = (c > ncyc + 2) ? 1'b1 : 1'($urandom);
            @(negedge clk);
            da    = out_data ^ 8'hA5;
            fresh = out_valid && (!pv || pr);
            if (pv && !pr) begin
                chk1("hold_vld", out_valid, 1'b1);
                chk8("hold_data", out_data, pd);
                chk8("hold_addr", rd_addr, paddr);
            end
            chk1($sformatf("wrap c%0d", c), loop_wrap, fresh && (da == wrap_a));
            if (out_valid && out_ready) begin
                chk8($sformatf("seq c%0d", c), da, exp_a);
                if (exp_a == wrap_a) nwrap = nwrap + 8'd1;
                chk8($sformatf("cnt c%0d", c), loop_cnt, nwrap);
                if (exp_a == wrap_a) exp_a = rv ? le : ls;
                else                 exp_a = rv ? exp_a - 8'd1 : exp_a + 8'd1;
            end
            pv = out_valid; pr = out_ready; pd = out_data; paddr = rd_addr;
            next_cycle();
        end
        @(negedge clk);
        chk1("round_end_busy", busy, 1'b0);
        chk1("round_end_vld", out_valid, 1'b0);
        next_cycle();
    endtask

    initial begin
        logic       found;
        logic [7:0] rls, rspan;

        rst = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        loop_start = 8'd0; loop_end = 8'd0; set_rev(1'b0);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        //   st sp ls     le     rdy busy vld daddr addr wrap err cnt
        add(1, 0, 8'd4,  8'd7,  1,  0,   0,  8'd0, 8'd0, 0,   0,  8'd0);
        add(0, 0, 8'd4,  8'd7,  1,  1,   0,  8'd0, 8'd4, 0,   0,  8'd0);
        add(0, 0, 8'd4,  8'd7,  1,  1,   1,  8'd4, 8'd5, 0,   0,  8'd0);
        add(0, 0, 8'd4,  8'd7,  1,  1,   1,  8'd5, 8'd6, 0,   0,  8'd0);
        add(0, 0, 8'd4,  8'd7,  1,  1,   1,  8'd6, 8'd7, 0,   0,  8'd0);
        add(0, 0, 8'd4,  8'd7,  1,  1,   1,  8'd7, 8'd4, 1,   0,  8'd1);
        add(0, 0, 8'd4,  8'd7,  1,  1,   1,  8'd4, 8'd5, 0,   0,  8'd1);
        add(0, 0, 8'd4,  8'd7,  1,  1,   1,  8'd5, 8'd6, 0,   0,  8'd1);
        add(0, 0, 8'd4,  8'd7,  1,  1,   1,  8'd6, 8'd7, 0,   0,  8'd1);
        add(0, 0, 8'd4,  8'd7,  1,  1,   1,  8'd7, 8'd4, 1,   0,  8'd2);
        add(0, 1, 8'd4,  8'd7,  1,  1,   1,  8'd4, 8'd5, 0,   0,  8'd2);
        add(0, 0, 8'd4,  8'd7,  1,  1,   0,  8'd0, 8'd5, 0,   0,  8'd2);
        add(0, 0, 8'd4,  8'd7,  1,  0,   0,  8'd0, 8'd5, 0,   0,  8'd2);
        add(1, 0, 8'd10, 8'd3,  1,  0,   0,  8'd0, 8'd5, 0,   0,  8'd2);
        add(0, 0, 8'd10, 8'd3,  1,  0,   0,  8'd0, 8'd5, 0,   1,  8'd2);
        add(0, 0, 8'd10, 8'd3,  1,  0,   0,  8'd0, 8'd5, 0,   0,  8'd2);
        add(1, 0, 8'd9,  8'd9,  1,  0,   0,  8'd0, 8'd5, 0,   0,  8'd2);
        add(0, 0, 8'd9,  8'd9,  1,  1,   0,  8'd0, 8'd9, 0,   0,  8'd0);
        add(0, 0, 8'd9,  8'd9,  1,  1,   1,  8'd9, 8'd9, 1,   0,  8'd1);
        add(0, 0, 8'd9,  8'd9,  1,  1,   1,  8'd9, 8'd9, 1,   0,  8'd2);
        add(1, 1, 8'd9,  8'd9,  1,  1,   1,  8'd9, 8'd9, 1,   0,  8'd3);
        add(1, 0, 8'd1,  8'd2,  1,  1,   0,  8'd0, 8'd9, 0,   0,  8'd3);
        add(0, 0, 8'd1,  8'd2,  1,  0,   0,  8'd0, 8'd9, 0,   0,  8'd3);
        add(0, 0, 8'd1,  8'd2,  1,  0,   0,  8'd0, 8'd9, 0,   0,  8'd3);

        foreach (tv[i]) begin
            start = tv[i].st; stop = tv[i].sp; out_ready = tv[i].rdy;
            loop_start = tv[i].ls; loop_end = tv[i].le;
            @(negedge clk);
            chk1($sformatf("v%0d busy", i), busy, tv[i].e_busy);
            chk1($sformatf("v%0d vld", i), out_valid, tv[i].e_vld);
            chk8($sformatf("v%0d rd_addr", i), rd_addr, tv[i].e_addr);
            chk1($sformatf("v%0d wrap", i), loop_wrap, tv[i].e_wrap);
            chk1($sformatf("v%0d err", i), cfg_err, tv[i].e_err);
            chk8($sformatf("v%0d cnt", i), loop_cnt, tv[i].e_cnt);
            if (tv[i].e_vld) chk8($sformatf("v%0d data", i), out_data, tv[i].e_daddr ^ 8'hA5);
            next_cycle();
        end

        // first-byte latency, stall with stop pending, then drain to idle
        start = 1'b1; stop = 1'b0; loop_start = 8'd20; loop_end = 8'd30; out_ready = 1'b0;
        @(negedge clk); chk1("lat0_vld", out_valid, 1'b0);
        next_cycle(); start = 1'b0;
        @(negedge clk); chk1("lat1_vld", out_valid, 1'b0);
        next_cycle();
        @(negedge clk); chk1("lat2_vld", out_valid, 1'b1); chk8("lat2_data", out_data, 8'd20 ^ 8'hA5);
        next_cycle(); stop = 1'b1;
        @(negedge clk); chk8("stop_data", out_data, 8'd20 ^ 8'hA5);
        next_cycle(); stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1($sformatf("drain%0d vld", k), out_valid, 1'b1);
            chk1($sformatf("drain%0d busy", k), busy, 1'b1);
            chk8($sformatf("drain%0d data", k), out_data, 8'd20 ^ 8'hA5);
            chk8($sformatf("drain%0d addr", k), rd_addr, 8'd21);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk); chk1("drain_acc_vld", out_valid, 1'b1);
        next_cycle();
        @(negedge clk); chk1("drain_done_busy", busy, 1'b0); chk1("drain_done_vld", out_valid, 1'b0);
        next_cycle();

        // synchronous reset in the middle of playback
        start = 1'b1; loop_start = 8'd0; loop_end = 8'd50; out_ready = 1'b1;
        next_cycle(); start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (rd_addr == 8'd5) found = 1'b1;
            else next_cycle();
        end
        chk1("rst_found_addr5", found, 1'b1);
        rst = 1'b1;
        next_cycle(); rst = 1'b0;
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_vld", out_valid, 1'b0);
        chk1("rst_wrap", loop_wrap, 1'b0);
        chk1("rst_err", cfg_err, 1'b0);
        chk8("rst_addr", rd_addr, 8'd0);
        chk8("rst_data", out_data, 8'd0);
        chk8("rst_cnt", loop_cnt, 8'd0);
        next_cycle();
        start = 1'b1; loop_start = 8'd2; loop_end = 8'd8;
        next_cycle(); start = 1'b0;
        next_cycle();
        @(negedge clk); chk1("restart_vld", out_valid, 1'b1); chk8("restart_data", out_data, 8'd2 ^ 8'hA5);
        next_cycle(); stop = 1'b1;
        next_cycle(); stop = 1'b0;
        next_cycle();

        run_round(8'd0, 8'd255, 1'b0, 120);
`ifdef LOOP_READER_REVERSE_EN
        run_round(8'd4, 8'd6, 1'b1, 40);
`endif
        for (int r = 0; r < 6; r++) begin
            rls   = 8'($urandom);
            rspan = 8'($urandom_range(0, 6));
            if (rls > 8'd255 - rspan) rls = 8'd255 - rspan;
`ifdef LOOP_READER_REVERSE_EN
            run_round(rls, rls + rspan, 1'($urandom), 60);
`else
            run_round(rls, rls + rspan, 1'b0, 60);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
